// File: rtl/ysyx_24110015_mem_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_mem_pkg
// Shared types for the IFU/LSU memory arbiter.
//   state_e        : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   ID_IFU, ID_LSU : requester identifiers, also used as bit positions in the
//                    one-hot grant vector produced by ysyx_24110015_arb_pick
// ---------------------------------------------------------------------------
package ysyx_24110015_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24110015_arb_pick.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_arb_pick
// Combinational winner selection between IFU and LSU.
// Configuration macro: YSYX_24110015_ARB_RR_EN
//   defined   : on a tie the requester that did not win last time is granted
//   undefined : on a tie the LSU is granted; i_last is ignored
// Ports:
//   i_valid [1:0] : request valids, indexed by requester ID
//   i_last        : ID of the requester granted most recently
//   o_grant [1:0] : one-hot grant, indexed by requester ID (zero if no valid)
// ---------------------------------------------------------------------------
module ysyx_24110015_arb_pick
  import ysyx_24110015_mem_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);

`ifndef YSYX_24110015_ARB_RR_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  always_comb begin
    o_grant = '0;
    if (i_valid[ID_LSU] && i_valid[ID_IFU]) begin
`ifdef YSYX_24110015_ARB_RR_EN
      if (i_last == ID_LSU) o_grant[ID_IFU] = 1'b1;
      else                  o_grant[ID_LSU] = 1'b1;
`else
      o_grant[ID_LSU] = 1'b1;
`endif
    end else begin
      // At most one valid: grant it directly.
      o_grant = i_valid;
    end
  end

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_mem_arbiter
// Shares a single SRAM port between the IFU (read-only) and the LSU
// (read/write). One transaction in flight at a time:
//   IDLE   : pick a winner, handshake, fire sram_ren / sram_wen for one cycle
//   ACCESS : capture sram_rdata (reads) or zero (writes) into resp_rdata
//   RESP   : hold the winner's resp_valid until its resp_ready
// Configuration macro: YSYX_24110015_ARB_RR_EN selects round-robin tie
// breaking (1-bit last-grant pointer); without it the LSU has priority.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   ifu_req_* / ifu_resp_*          : IFU request / response handshakes
//   lsu_req_* / lsu_resp_*          : LSU request (wen/addr/wdata/wmask) and
//                                     response handshakes
//   resp_rdata                      : response data for whichever requester
//   sram_*                          : single SRAM port, rdata one cycle late
// ---------------------------------------------------------------------------
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_resp_valid,
  input  logic                    ifu_resp_ready,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic                    lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
  output logic                    lsu_resp_valid,
  input  logic                    lsu_resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    sram_ren,
  output logic [ADDR_WIDTH-1:0]   sram_raddr,
  output logic                    sram_wen,
  output logic [ADDR_WIDTH-1:0]   sram_waddr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH/8-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    r_winner;
  logic                    r_is_write;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              w_grant;
  logic                    w_last;
  logic                    w_hs;
  logic                    w_is_write;
  logic [ADDR_WIDTH-1:0]   w_addr;

`ifdef YSYX_24110015_ARB_RR_EN
  logic r_last;
  assign w_last = r_last;
`else
  assign w_last = ID_LSU;
`endif

  ysyx_24110015_arb_pick u_pick (
    .i_valid ({lsu_req_valid, ifu_req_valid}),
    .i_last  (w_last),
    .o_grant (w_grant)
  );

  // A grant is only ever issued to a valid requester, so a non-zero grant in
  // IDLE is the handshake.
  assign w_hs       = (r_state == ST_IDLE) && (|w_grant);
  // Only an LSU grant can produce a write.
  assign w_is_write = w_grant[ID_LSU] & lsu_req_wen;
  assign w_addr     = w_grant[ID_LSU] ? lsu_req_addr : ifu_req_addr;

  assign sram_raddr = w_addr;
  assign sram_waddr = w_addr;
  assign sram_wdata = lsu_req_wdata;
  assign sram_wmask = lsu_req_wmask;
  assign resp_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    sram_ren       = 1'b0;
    sram_wen       = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // rst_n gating keeps ready and enables low while reset is held.
        if (rst_n && w_hs) begin
          ifu_req_ready = w_grant[ID_IFU];
          lsu_req_ready = w_grant[ID_LSU];
          sram_ren      = ~w_is_write;
          sram_wen      = w_is_write;
          w_state_nxt   = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP: begin
        ifu_resp_valid = (r_winner == ID_IFU);
        lsu_resp_valid = (r_winner == ID_LSU);
        if ((r_winner == ID_IFU && ifu_resp_ready) ||
            (r_winner == ID_LSU && lsu_resp_ready))
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winner   <= ID_IFU;
      r_is_write <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_hs) begin
        r_winner   <= w_grant[ID_LSU] ? ID_LSU : ID_IFU;
        r_is_write <= w_is_write;
      end
      if (r_state == ST_ACCESS)
        r_rdata <= r_is_write ? '0 : sram_rdata;
    end
  end

`ifdef YSYX_24110015_ARB_RR_EN
  // Reset as "LSU granted last" so the first tie goes to the IFU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_last <= ID_LSU;
    else if (w_hs) r_last <= w_grant[ID_LSU] ? ID_LSU : ID_IFU;
  end
`endif

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
module tb_ysyx_24110015_mem_arbiter;

`ifdef YSYX_24110015_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_req_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic [31:0] resp_rdata;
  logic        sram_ren, sram_wen;
  logic [31:0] sram_raddr, sram_waddr, sram_wdata;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_rdata = 32'hFFFF_FFFF;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_24110015_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .resp_rdata     (resp_rdata),
    .sram_ren       (sram_ren),
    .sram_raddr     (sram_raddr),
    .sram_wen       (sram_wen),
    .sram_waddr     (sram_waddr),
    .sram_wdata     (sram_wdata),
    .sram_wmask     (sram_wmask),
    .sram_rdata     (sram_rdata)
  );

  // SRAM model: 0x8000_0000 holds 0x0000_0413, every other word holds
  // addr ^ 0xA5A5_0000. Data appears the cycle after sram_ren.
  always @(posedge clk)
    if (sram_ren)
      sram_rdata <= (sram_raddr == 32'h8000_0000) ? 32'h0000_0413
                                                  : (sram_raddr ^ 32'hA5A5_0000);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One full transaction with immediate response acceptance.
  task automatic xact(input bit lsu, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] exp);
    @(posedge clk); #1;
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_req_wen = wr; lsu_req_addr = addr;
      lsu_req_wdata = wdata; lsu_req_wmask = mask;
    end else begin
      ifu_req_valid = 1'b1; ifu_req_addr = addr;
    end
    @(negedge clk);
    chk("hs_ifu_ready", ifu_req_ready, !lsu);
    chk("hs_lsu_ready", lsu_req_ready, lsu);
    chk("hs_sram_ren", sram_ren, !wr);
    chk("hs_sram_wen", sram_wen, wr);
    if (wr) begin
      chk("hs_waddr", sram_waddr, addr);
      chk("hs_wdata", sram_wdata, wdata);
      chk("hs_wmask", sram_wmask, mask);
    end else begin
      chk("hs_raddr", sram_raddr, addr);
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);
    chk("acc_ready", {ifu_req_ready, lsu_req_ready}, 0);
    chk("acc_en", {sram_ren, sram_wen}, 0);
    chk("acc_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    @(posedge clk); #1;
    ifu_resp_ready = !lsu; lsu_resp_ready = lsu;
    @(negedge clk);
    chk("rsp_ifu_valid", ifu_resp_valid, !lsu);
    chk("rsp_lsu_valid", lsu_resp_valid, lsu);
    chk("rsp_rdata", resp_rdata, exp);
    @(posedge clk); #1;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    @(negedge clk);
    chk("post_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_lsu;
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_0100;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0; lsu_resp_ready = 1'b0;

    // Reset state with requests pending
    @(negedge clk);
    chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_en", {sram_ren, sram_wen}, 0);
    chk("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // IFU read, LSU write, LSU read
    xact(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413);
    xact(1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0);
    xact(1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'h0, 32'h25A5_0100);
    xact(1'b1, 1'b1, 32'h8000_0200, 32'h1234_5678, 4'h3, 32'h0);

    // Both requesters valid every cycle; reset first so the pointer is known
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    ifu_req_addr = 32'h8000_0000; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1'b0;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_lsu = RR ? (i % 2 == 1) : 1'b1;
      @(negedge clk);
      chk("tie_lsu_ready", lsu_req_ready, exp_lsu);
      chk("tie_ifu_ready", ifu_req_ready, !exp_lsu);
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("tie_lsu_resp", lsu_resp_valid, exp_lsu);
      chk("tie_ifu_resp", ifu_resp_valid, !exp_lsu);
      chk("tie_rdata", resp_rdata, exp_lsu ? 32'h25A5_0100 : 32'h0000_0413);
      @(posedge clk); #1;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;

    // Response back-pressure for 5 cycles; LSU pulses a write during RESP
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008;
    @(posedge clk); #1; ifu_req_valid = 1'b0;
    @(posedge clk); #1;
    lsu_req_wen = 1'b1; lsu_req_wdata = 32'hCAFE_F00D; lsu_req_wmask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      lsu_req_valid = (i == 0);
      @(negedge clk);
      chk("hold_valid", ifu_resp_valid, 1);
      chk("hold_rdata", resp_rdata, 32'h25A5_0008);
      chk("hold_ready", {ifu_req_ready, lsu_req_ready}, 0);
      chk("hold_en", {sram_ren, sram_wen}, 0);
      @(posedge clk); #1;
    end
    lsu_req_valid = 1'b0; ifu_resp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", ifu_resp_valid, 1);
    @(posedge clk); #1; ifu_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_no_access", {sram_ren, sram_wen}, 0);
      chk("drop_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
      @(posedge clk); #1;
    end

    // Reset while in RESP
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    @(posedge clk); #1; ifu_req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", ifu_resp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", ifu_resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    xact(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h25A5_0004);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
